// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: computes A - B - B_in one bit per clock,
//   LSB first, with a single full-subtractor cell and a borrow flip-flop.
//   A start/done handshake allows back-to-back operations.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, active-low
//   start  in   request; sampled only in IDLE
//   A, B   in   WIDTH-bit minuend/subtrahend, latched when start is accepted
//   B_in   in   borrow-in, latched when start is accepted
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse; diff/B_out valid from this cycle
//   diff   out  (A - B - B_in) mod 2^WIDTH, held until the next completion
//   B_out  out  final borrow (1 iff A < B + B_in)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; diff/B_out hold the last result
// SHIFT | one bit per edge, counter selects bit; WIDTH edges total
// DONE  | done pulse for one cycle, then back to IDLE

module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             B_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             B_out
);

   // Counter needs at least one bit even when WIDTH=1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] d_msb;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      a_bit   = a_sr[0];
      b_bit   = b_sr[0];
      d_bit   = a_bit ^ b_bit ^ br;
      br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
      // Result enters from the MSB end so after WIDTH shifts bit 0 lands at [0].
      d_msb            = '0;
      d_msb[WIDTH-1]   = d_bit;
      res_next         = (res_sr >> 1) | d_msb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         B_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  br    <= B_in;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               br     <= br_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  diff  <= res_next;
                  B_out <= br_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed steps plus exhaustive sweep,
// expected results queued at issue time and popped at each done pulse.

module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         B_in = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         B_out;

   typedef struct packed {
      logic [W-1:0] d;
      logic         b;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .B_in  (B_in),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .B_out (B_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int a, input int b, input int bin);
      exp_t e;
      e.d = W'((a - b - bin) & ((1 << W) - 1));
      e.b = (a < b + bin);
      return e;
   endfunction

   // From the current negedge, wait for done; counts busy cycles and total cycles.
   task automatic wait_done(output int busy_cyc, output int total);
      busy_cyc = 0;
      total    = 0;
      while (done !== 1'b1 && total < 20) begin
         chk("busy_done_excl", {31'b0, busy & done}, 32'd0);
         if (busy === 1'b1) busy_cyc++;
         total++;
         @(negedge clk);
      end
      chk("done_timeout", {31'b0, done}, 32'd1);
      chk("busy_at_done", {31'b0, busy}, 32'd0);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_diff"}, {28'b0, diff}, {28'b0, e.d});
         chk({tag, "_bout"}, {31'b0, B_out}, {31'b0, e.b});
      end
   endtask

   task automatic run_op(input string tag, input int a, input int b, input int bin);
      int bc, tot;
      A     = W'(a);
      B     = W'(b);
      B_in  = bin[0];
      start = 1'b1;
      sb.push_back(model(a, b, bin));
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_after_accept"}, {31'b0, busy}, 32'd1);
      wait_done(bc, tot);
      chk({tag, "_busy_cycles"}, bc, W);
      pop_cmp(tag);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
   endtask

   task automatic idle_quiet(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      chk({tag, "_no_extra_done"}, seen, 0);
   endtask

   initial begin
      int bc, tot;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_diff", {28'b0, diff}, 32'd0);
      chk("rst_bout", {31'b0, B_out}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed operations
      run_op("op_9_3", 9, 3, 0);
      run_op("op_3_9", 3, 9, 0);
      run_op("op_0_0_b", 0, 0, 1);
      run_op("op_15_15", 15, 15, 0);

      // Start pulsed while busy is ignored
      A = 4'd7; B = 4'd7; B_in = 1'b0; start = 1'b1;
      sb.push_back(model(7, 7, 0));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 4'd12; B = 4'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(bc, tot);
      pop_cmp("ignore");
      idle_quiet("ignore", 10);
      chk("ignore_sb_empty", sb.size(), 0);

      // Start held high: one op every W+2 cycles, in-flight operand change ignored
      A = 4'd5; B = 4'd2; B_in = 1'b0; start = 1'b1;
      sb.push_back(model(5, 2, 0));
      sb.push_back(model(5, 2, 0));
      sb.push_back(model(5, 2, 0));
      @(negedge clk);
      wait_done(bc, tot);
      pop_cmp("hold1");
      @(negedge clk);
      wait_done(bc, tot);
      chk("hold_period", tot + 1, W + 2);
      pop_cmp("hold2");
      // third accept: find busy rising, then perturb A and drop start
      tot = 0;
      do begin
         @(negedge clk);
         tot++;
      end while (busy !== 1'b1 && tot < 10);
      chk("hold3_accept", {31'b0, busy}, 32'd1);
      A = 4'd1;
      start = 1'b0;
      wait_done(bc, tot);
      pop_cmp("hold3");

      // Asynchronous reset mid-SHIFT
      @(negedge clk);
      A = 4'd9; B = 4'd3; B_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      chk("arst_diff", {28'b0, diff}, 32'd0);
      chk("arst_bout", {31'b0, B_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_quiet("arst", 8);
      chk("arst_diff_after", {28'b0, diff}, 32'd0);
      run_op("op_8_1", 8, 1, 0);

      // Exhaustive sweep
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               run_op("exh", a, b, c);

      chk("final_sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial binary subtractor computing A - B - B_in, LSB first, one bit per clock. It uses a single full-subtractor cell and a borrow flip-flop. This is the multi-cycle, area-minimal counterpart to the combinational adder blocks in Basic. It has a start/done handshake so a bench or controller can issue back-to-back operations.

Parameters:
WIDTH, 4, operand/result width in bits; legal range >= 1.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend, unsigned; latched when start accepted
B  input  WIDTH  subtrahend, unsigned; latched when start accepted
B_in  input  1  borrow-in; latched when start accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; diff/B_out valid from this cycle
diff  output  WIDTH  result (A - B - B_in) mod 2^WIDTH
B_out  output  1  borrow-out; 1 iff A < B + B_in (unsigned)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, diff=0, B_out=0. Internal shift registers, borrow FF and bit counter are cleared.
- Reset mid-operation aborts the operation. No done is produced. The outputs read 0 after reset releases.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at edge k, latch A, B and B_in; borrow FF <= B_in; counter <= 0; go to SHIFT; busy=1 after edge k. Otherwise stay in IDLE.
- SHIFT: each edge processes bit i = counter (LSB first).
  - Output bit: d = a^b^br.
  - Next borrow: br' = (~a & b) | (~(a^b) & br).
  - d shifts into the internal result register from the MSB end. Operand registers shift right. Counter increments.
  - On the edge processing bit WIDTH-1 (edge k+WIDTH): copy the internal result to diff, set B_out <= br', go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
- Latency: done is high in the cycle following edge k+WIDTH. The next start can be accepted at edge k+WIDTH+2 at the earliest.
- start while in SHIFT or DONE is ignored. It is not queued, and the latched operands are unaffected.
- Changes to A, B and B_in after the accepting edge have no effect on the operation in flight.
- diff and B_out change only on the edge entering DONE, or on reset. They hold their last result through IDLE and through the next operation until that operation completes.
- busy and done are never high together.
- WIDTH=1: one SHIFT cycle; the same rules apply.
- Arithmetic: unsigned modulo 2^WIDTH. B_out is the final borrow, equal to the carry-out of A + ~B + ~B_in inverted.
- The counter must be wide enough to hold WIDTH-1.

Test Plan:
- WIDTH=4; reset; start with A=9, B=3, B_in=0 -> done pulses one cycle after the 4th edge following acceptance; diff=6, B_out=0; busy high for exactly 4 cycles before done.
- A=3, B=9, B_in=0 -> diff=10, B_out=1. Then A=0, B=0, B_in=1 -> diff=15, B_out=1. Then A=15, B=15, B_in=0 -> diff=0, B_out=0.
- Hold start high continuously with A=5, B=2: operations are accepted only in IDLE, one every WIDTH+2 cycles; every done shows diff=3, B_out=0. Change A to 1 mid-operation -> the in-flight result is still 3.
- Pulse start with A=12, B=4 while busy (2 cycles after the first start of A=7, B=7) -> the second request is ignored; the single done shows diff=0, B_out=0.
- Drive rst_n low mid-SHIFT, asynchronously between edges -> busy, done, diff and B_out go to 0 immediately; no done follows. A new start with A=8, B=1 then yields diff=7.
- Exhaustive WIDTH=4 check of all A, B and B_in values against a reference model: diff == (A-B-B_in)&15 and B_out == (A < B+B_in).
